// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move sequencer: FSM states,
// full-step coil patterns and the register-file index written on each step.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STEP,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [3:0] PH_A = 4'b0001;
    localparam logic [3:0] PH_B = 4'b0010;
    localparam logic [3:0] PH_C = 4'b0100;
    localparam logic [3:0] PH_D = 4'b1000;

    localparam logic [1:0] WR_SEL_POS = 2'b10;

    // Next coil pattern for one full step; an illegal pattern recovers to PH_A.
    function automatic logic [3:0] phase_next(input logic [3:0] ph, input logic up);
        logic [3:0] nxt;
        case (ph)
            PH_A:    nxt = up ? PH_B : PH_D;
            PH_B:    nxt = up ? PH_C : PH_A;
            PH_C:    nxt = up ? PH_D : PH_B;
            PH_D:    nxt = up ? PH_A : PH_C;
            default: nxt = PH_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that times the WAIT interval between steps.
// o_expired is high while the count is zero.
module step_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper motor move sequencer: walks position toward a latched target one full
// step at a time, writing each new position back to the register file.
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] target,
    input  logic [7:0] delay,
    output logic [3:0] phase,
    output logic [7:0] position,
    output logic       pos_wr,
    output logic [1:0] wr_select,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done
);

    localparam int TW = 8 + $clog2(TICK_DIV);

    state_t         r_state;
    state_t         w_next_state;
    logic [7:0]     r_target;
    logic [7:0]     r_delay;
    logic           r_dir_up;
    logic [7:0]     r_position;
    logic [3:0]     r_phase;
    logic           r_busy;
    logic           r_done;
    logic           r_pos_wr;

    logic [7:0]     w_delay_src;
    logic [7:0]     w_delay_eff;
    logic [TW-1:0]  w_load_val;
    logic           w_timer_load;
    logic           w_timer_en;
    logic           w_expired;

    // The first WAIT of a move loads from the delay input being latched that cycle.
    assign w_delay_src  = (r_state == ST_IDLE) ? delay : r_delay;
    assign w_delay_eff  = (w_delay_src == 8'd0) ? 8'd1 : w_delay_src;
    assign w_load_val   = TW'(w_delay_eff) * TW'(TICK_DIV) - TW'(1);
    assign w_timer_load = (w_next_state == ST_WAIT) && (r_state != ST_WAIT);
    assign w_timer_en   = (r_state == ST_WAIT);

    step_timer #(
        .W (TW)
    ) u_step_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_load_val (w_load_val),
        .i_en       (w_timer_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (target != r_position) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_STEP:  w_next_state = abort ? ST_IDLE : ST_WRITE;
            ST_WRITE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = (r_position == r_target) ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target   <= 8'h00;
            r_delay    <= 8'h00;
            r_dir_up   <= 1'b0;
            r_position <= 8'h00;
            r_phase    <= PH_A;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pos_wr   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_target <= target;
                r_delay  <= delay;
                r_dir_up <= (target > r_position);
            end
            if ((r_state == ST_STEP) && !abort) begin
                r_position <= r_dir_up ? r_position + 8'd1 : r_position - 8'd1;
                r_phase    <= phase_next(r_phase, r_dir_up);
            end
            r_busy   <= (w_next_state == ST_WAIT) || (w_next_state == ST_STEP) ||
                        (w_next_state == ST_WRITE);
            r_done   <= (w_next_state == ST_DONE);
            r_pos_wr <= (w_next_state == ST_WRITE);
        end
    end

    assign phase     = r_phase;
    assign position  = r_position;
    assign pos_wr    = r_pos_wr;
    assign wr_select = WR_SEL_POS;
    assign wr_data   = r_position;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
